jt10_adpcm_rom: RTL and testbench
=================================

# jt10_adpcm_rom

Memory-side responder for the YM2610 ADPCM sample ROM ports. It watches the ADPCM-A (bank + 20-bit address, output-enable) and ADPCM-B (24-bit address, output-enable) read requests issued by the chip core. It serves them from a shared 16-bit external memory through a req/ack handshake, and returns the addressed byte on each port's data bus. Each port has a one-word cache so that consecutive nibble/byte reads within a word cost no memory transaction.

## Interface
Parameters:
- MEM_AW, 24: word-address width of the external memory.
- A_BASE, 25'h000000: byte offset of the ADPCM-A region in memory.
- B_BASE, 25'h1000000: byte offset of the ADPCM-B region in memory.

Ports:
- clk  in  1  system clock; the block has one clock.
- rst_n  in  1  reset, asynchronous, active-low.
- adpcma_addr  in  20  ADPCM-A byte address from the chip core.
- adpcma_bank  in  4  ADPCM-A bank; the full A byte address is {bank, addr}.
- adpcma_roe_n  in  1  ADPCM-A read enable, active-low.
- adpcma_data  out  8  ADPCM-A byte returned to the core.
- adpcma_ok  out  1  high when adpcma_data belongs to the current A address.
- adpcmb_addr  in  24  ADPCM-B byte address.
- adpcmb_roe_n  in  1  ADPCM-B read enable, active-low.
- adpcmb_data  out  8  ADPCM-B byte returned to the core.
- adpcmb_ok  out  1  high when adpcmb_data belongs to the current B address.
- mem_addr  out  MEM_AW  word address to external memory.
- mem_req  out  1  memory request.
- mem_ack  in  1  one-cycle pulse; mem_din is valid in the same cycle.
- mem_din  in  16  memory word; the byte at an even address is in [7:0], the byte at an odd address is in [15:8].

## Operation
- Byte address formation:
  - A: byte_a = A_BASE + {bank, addr}, 25 bits, overflow truncated.
  - B: byte_b = B_BASE + addr, 25 bits, overflow truncated.
  - Word address = byte[MEM_AW:1]; byte[0] selects the half of the word.
- Per-port cache: valid bit, word tag (MEM_AW bits), data (16 bits).
- Hit: roe_n low, valid set, and tag equals the current word address.
- Miss: roe_n low and not a hit.
- Every cycle on a hit, the port's data register loads the selected byte and ok goes high.
- On any address change, ok drops in the same cycle combinationally. It rises again on the cycle the data register is updated.
- With roe_n high, data holds its value and ok holds its value; no request is generated.
- FSM states:
  - IDLE: evaluate misses and choose one.
    - Only A misses -> FETCH_A.
    - Only B misses -> FETCH_B.
    - Both miss -> the port not served last (round-robin flag; reset value selects A).
  - FETCH_x: mem_req=1, mem_addr = the latched word address. Stay until mem_ack.
    - On ack: write tag/data/valid for port x, update the round-robin flag, go to IDLE.
- The word address is latched on entering FETCH. Address changes during FETCH do not alter mem_addr. The fetched word is still cached under the latched tag; IDLE then re-evaluates and may miss again.
- A fill completes the data byte only if the latched tag still matches the current address. Otherwise ok stays low.

## Timing
- Reset values:
  - mem_req=0, mem_addr=0.
  - adpcma_data=0, adpcmb_data=0.
  - adpcma_ok=0, adpcmb_ok=0.
  - Cache valid bits cleared; FSM in IDLE; round-robin selects A.
- Hit latency: the address becomes stable at edge N; data and ok are registered at edge N+1.
- Miss latency:
  - Miss seen in IDLE at edge N -> mem_req high after edge N.
  - Ack at edge M -> data/ok registered at edge M+1. Minimum miss latency is 3 cycles with an immediate ack.
- mem_req stays high, with mem_addr stable, from the FETCH entry until the ack cycle inclusive. It is low in the cycle after the ack, so there is at least one idle cycle between requests.
- mem_ack while in IDLE (stray, or late after a reset) is ignored.
- Reset asserted mid-FETCH: mem_req drops asynchronously and the cache is invalidated. A pending ack after reset release is ignored.
- Simultaneous A and B misses are served back-to-back. Neither port can be starved by the other for more than one fetch.

## Test plan
- Reset, then A reads bank=0, addr=0x00000, with memory word 0 = 0xBEEF and an immediate ack -> one request, mem_addr=0x000000; adpcma_data=0xEF, ok=1 three cycles after the miss. Then addr=0x00001 -> no request; data=0xBE one cycle later.
- B reads addr=0x000004 with defaults -> mem_addr=0x800002; with mem_din=0x1234, adpcmb_data=0x34.
- Both A and B miss in the same cycle -> A fetched first, B second. A repeat simultaneous miss -> B first.
- A address changes from 0x00010 to 0x00020 during FETCH, with ack delayed 5 cycles -> mem_addr stays 0x000008 until the ack; a second request to 0x000010 follows; ok stays low until the second fill.
- rst_n pulsed low while mem_req=1, and ack arrives 2 cycles after release -> mem_req=0 immediately, all outputs return to reset values, the ack is ignored, and the next A read issues a fresh request.
- roe_n high with the address toggling -> no mem_req, and data holds its value.

Source files
------------

// File: rtl/jt10_adpcm_rom.sv
// Purpose: serves YM2610 ADPCM-A/B byte reads from a shared 16-bit memory, one-word cache per port.
// Latency: hit -> data/ok one cycle after the address settles; miss -> 3 cycles minimum (req, ack, hit).
// Backpressure: mem_req holds with a stable mem_addr until mem_ack; the core waits on adpcm*_ok.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   adpcma_addr/bank/roe_n -> data/ok ADPCM-A request and returned byte
//   adpcmb_addr/roe_n      -> data/ok ADPCM-B request and returned byte
//   mem_addr, mem_req, mem_ack, mem_din   word-wide req/ack memory port
module jt10_adpcm_rom #(
  parameter int          MEM_AW = 24,          // must not exceed 24 (byte addresses are 25 bits)
  parameter logic [24:0] A_BASE = 25'h0000000,
  parameter logic [24:0] B_BASE = 25'h1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [19:0]       adpcma_addr,
  input  logic [3:0]        adpcma_bank,
  input  logic              adpcma_roe_n,
  output logic [7:0]        adpcma_data,
  output logic              adpcma_ok,
  input  logic [23:0]       adpcmb_addr,
  input  logic              adpcmb_roe_n,
  output logic [7:0]        adpcmb_data,
  output logic              adpcmb_ok,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [15:0]       mem_din
);

  typedef enum logic [1:0] {IDLE, FETCH_A, FETCH_B} state_t;

  state_t            state;
  logic              rr_b;          // set: B wins the next simultaneous miss

  logic              ca_vld, cb_vld;
  logic [MEM_AW-1:0] ca_tag, cb_tag;
  logic [15:0]       ca_dat, cb_dat;

  // Address that the current data register content belongs to
  logic              a_ok_q, b_ok_q;
  logic [23:0]       a_addr_q, b_addr_q;

  logic [23:0]       cur_a;
  logic [24:0]       byte_a, byte_b;
  logic [MEM_AW-1:0] word_a, word_b;
  logic              hit_a, hit_b, miss_a, miss_b;
  logic [7:0]        sel_a, sel_b;

  assign cur_a  = {adpcma_bank, adpcma_addr};
  assign byte_a = A_BASE + {1'b0, cur_a};
  assign byte_b = B_BASE + {1'b0, adpcmb_addr};
  assign word_a = byte_a[MEM_AW:1];
  assign word_b = byte_b[MEM_AW:1];

  assign hit_a  = !adpcma_roe_n && ca_vld && (ca_tag == word_a);
  assign hit_b  = !adpcmb_roe_n && cb_vld && (cb_tag == word_b);
  assign miss_a = !adpcma_roe_n && !hit_a;
  assign miss_b = !adpcmb_roe_n && !hit_b;

  assign sel_a  = byte_a[0] ? ca_dat[15:8] : ca_dat[7:0];
  assign sel_b  = byte_b[0] ? cb_dat[15:8] : cb_dat[7:0];

  // ok falls in the same cycle the address moves away from the byte held in data
  assign adpcma_ok = a_ok_q && (cur_a == a_addr_q);
  assign adpcmb_ok = b_ok_q && (adpcmb_addr == b_addr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_b        <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      ca_vld      <= 1'b0;
      cb_vld      <= 1'b0;
      ca_tag      <= '0;
      cb_tag      <= '0;
      ca_dat      <= '0;
      cb_dat      <= '0;
      adpcma_data <= '0;
      adpcmb_data <= '0;
      a_ok_q      <= 1'b0;
      b_ok_q      <= 1'b0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
    end else begin
      // Data path runs every cycle independently of the fetch engine
      if (hit_a) begin
        adpcma_data <= sel_a;
        a_ok_q      <= 1'b1;
        a_addr_q    <= cur_a;
      end
      if (hit_b) begin
        adpcmb_data <= sel_b;
        b_ok_q      <= 1'b1;
        b_addr_q    <= adpcmb_addr;
      end

      case (state)
        IDLE: begin
          if (miss_a && (!miss_b || !rr_b)) begin
            state    <= FETCH_A;
            mem_req  <= 1'b1;
            mem_addr <= word_a;
          end else if (miss_b) begin
            state    <= FETCH_B;
            mem_req  <= 1'b1;
            mem_addr <= word_b;
          end
        end
        // The fill is cached under the latched address even if the port has
        // moved on; the next IDLE pass then sees a fresh miss.
        FETCH_A: begin
          if (mem_ack) begin
            ca_vld  <= 1'b1;
            ca_tag  <= mem_addr;
            ca_dat  <= mem_din;
            rr_b    <= 1'b1;
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        FETCH_B: begin
          if (mem_ack) begin
            cb_vld  <= 1'b1;
            cb_tag  <= mem_addr;
            cb_dat  <= mem_din;
            rr_b    <= 1'b0;
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jt10_adpcm_rom.sv
// Bench for jt10_adpcm_rom: directed scenarios then randomized reads against a
// behavioural memory/cache model; a responder process logs every request.
// Inputs change at negedge or posedge+2; outputs are sampled at negedge.
module tb_jt10_adpcm_rom;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] adpcma_addr;
  logic [3:0]  adpcma_bank;
  logic        adpcma_roe_n;
  logic [7:0]  adpcma_data;
  logic        adpcma_ok;
  logic [23:0] adpcmb_addr;
  logic        adpcmb_roe_n;
  logic [7:0]  adpcmb_data;
  logic        adpcmb_ok;
  logic [23:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_din;

  always #5 clk = ~clk;

  jt10_adpcm_rom dut (
    .clk(clk), .rst_n(rst_n),
    .adpcma_addr(adpcma_addr), .adpcma_bank(adpcma_bank), .adpcma_roe_n(adpcma_roe_n),
    .adpcma_data(adpcma_data), .adpcma_ok(adpcma_ok),
    .adpcmb_addr(adpcmb_addr), .adpcmb_roe_n(adpcmb_roe_n),
    .adpcmb_data(adpcmb_data), .adpcmb_ok(adpcmb_ok),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_din(mem_din)
  );

  int          total = 0;
  int          bad   = 0;
  logic [23:0] req_log[$];
  int          moved    = 0;
  int          ack_dly  = 0;
  bit          auto_ack = 1'b1;
  bit          stray_ack = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory contents as seen by the core
  function automatic logic [15:0] memfun(input logic [23:0] w);
    if (w == 24'h000000) return 16'hBEEF;
    if (w == 24'h800002) return 16'h1234;
    return {w[15:8] ^ w[23:16] ^ 8'hA7, w[7:0] ^ 8'h3C};
  endfunction

  function automatic logic [24:0] a_byte(input logic [3:0] bank, input logic [19:0] addr);
    return 25'h0000000 + {1'b0, bank, addr};
  endfunction

  function automatic logic [24:0] b_byte(input logic [23:0] addr);
    return 25'h1000000 + {1'b0, addr};
  endfunction

  function automatic logic [7:0] byte_of(input logic [24:0] b);
    logic [15:0] d;
    d = memfun(b[24:1]);
    return b[0] ? d[15:8] : d[7:0];
  endfunction

  // Memory responder: logs each new request, acks after ack_dly waiting cycles
  initial begin
    int w;
    bit pend;
    w = 0; pend = 1'b0;
    mem_ack = 1'b0; mem_din = 16'h0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (stray_ack) begin
        mem_ack = 1'b1; mem_din = 16'hDEAD; stray_ack = 1'b0;
      end
      if (!mem_req) pend = 1'b0;
      else begin
        if (!pend) begin
          pend = 1'b1; w = 0; req_log.push_back(mem_addr);
        end else if (mem_addr != req_log[$]) moved++;
        if (auto_ack) begin
          if (w >= ack_dly) begin
            mem_ack = 1'b1; mem_din = memfun(mem_addr); pend = 1'b0;
          end else w++;
        end
      end
    end
  end

  task automatic wait_ok(input string tag, input bit wa, input bit wb, input int budget);
    int n;
    n = 0;
    #1;
    while (n < budget && !((!wa || adpcma_ok) && (!wb || adpcmb_ok))) begin
      @(negedge clk); n++;
    end
    chk({tag, "_timeout"}, 32'(n < budget), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    bit saw_req;
    logic [23:0] ma_w, mb_w;
    bit ma_v, mb_v;
    logic [24:0] ab, bb;

    rst_n = 1'b0;
    adpcma_addr = '0; adpcma_bank = '0; adpcma_roe_n = 1'b1;
    adpcmb_addr = '0; adpcmb_roe_n = 1'b1;
    #12;
    chk("rst_req",  32'(mem_req), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_da",   32'(adpcma_data), 0);
    chk("rst_db",   32'(adpcmb_data), 0);
    chk("rst_oka",  32'(adpcma_ok), 0);
    chk("rst_okb",  32'(adpcmb_ok), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_noreq", 32'(req_log.size()), 0);

    // 1: A miss with immediate ack, then odd byte of the same word
    adpcma_roe_n = 1'b0; adpcma_bank = 4'h0; adpcma_addr = 20'h00000;
    @(posedge clk);
    @(negedge clk); chk("t1_req_hi", 32'(mem_req), 1);
    @(negedge clk); chk("t1_ok_early", 32'(adpcma_ok), 0);
    @(negedge clk);
    chk("t1_ok", 32'(adpcma_ok), 1);
    chk("t1_data", 32'(adpcma_data), 32'hEF);
    chk("t1_nreq", 32'(req_log.size()), 1);
    chk("t1_addr", 32'(req_log[0]), 0);
    adpcma_addr = 20'h00001;
    #1 chk("t1_okdrop", 32'(adpcma_ok), 0);
    @(negedge clk);
    chk("t1_ok2", 32'(adpcma_ok), 1);
    chk("t1_data2", 32'(adpcma_data), 32'hBE);
    chk("t1_nreq2", 32'(req_log.size()), 1);

    // 2: B region offset
    base = req_log.size();
    adpcmb_roe_n = 1'b0; adpcmb_addr = 24'h000004;
    wait_ok("t2", 0, 1, 20);
    chk("t2_addr", 32'(req_log[base]), 32'h800002);
    chk("t2_data", 32'(adpcmb_data), 32'h34);

    // 3: round-robin between simultaneous misses
    ack_dly = 1;
    base = req_log.size();
    adpcma_addr = 20'h00100; adpcmb_addr = 24'h000200;
    wait_ok("t3a", 1, 1, 40);
    chk("t3a_n", 32'(req_log.size() - base), 2);
    chk("t3a_first", 32'(req_log[base]), 32'h000080);
    chk("t3a_second", 32'(req_log[base+1]), 32'h800100);
    chk("t3a_da", 32'(adpcma_data), 32'(byte_of(a_byte(4'h0, 20'h00100))));
    chk("t3a_db", 32'(adpcmb_data), 32'(byte_of(b_byte(24'h000200))));
    adpcma_addr = 20'h00300;
    wait_ok("t3b", 1, 1, 40);
    base = req_log.size();
    adpcma_addr = 20'h00400; adpcmb_addr = 24'h000500;
    wait_ok("t3c", 1, 1, 40);
    chk("t3c_n", 32'(req_log.size() - base), 2);
    chk("t3c_first", 32'(req_log[base]), 32'h800280);
    chk("t3c_second", 32'(req_log[base+1]), 32'h000200);

    // 4: address moves during a slow fetch
    ack_dly = 5;
    moved = 0;
    base = req_log.size();
    adpcma_addr = 20'h00010;
    n = 0;
    while (req_log.size() == base && n < 20) begin @(negedge clk); n++; end
    chk("t4_req_seen", 32'(n < 20), 1);
    adpcma_addr = 20'h00020;
    wait_ok("t4", 1, 0, 60);
    chk("t4_n_at_ok", 32'(req_log.size() - base), 2);
    chk("t4_first", 32'(req_log[base]), 32'h000008);
    chk("t4_second", 32'(req_log[base+1]), 32'h000010);
    chk("t4_stable", 32'(moved), 0);
    chk("t4_data", 32'(adpcma_data), 32'(byte_of(a_byte(4'h0, 20'h00020))));

    // 5: reset in the middle of a fetch, late ack afterwards
    ack_dly = 0;
    auto_ack = 1'b0;
    adpcma_addr = 20'h00040;
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    chk("t5_req_seen", 32'(mem_req), 1);
    rst_n = 1'b0; adpcma_roe_n = 1'b1; adpcmb_roe_n = 1'b1;
    #1;
    chk("t5_req", 32'(mem_req), 0);
    chk("t5_addr", 32'(mem_addr), 0);
    chk("t5_da", 32'(adpcma_data), 0);
    chk("t5_db", 32'(adpcmb_data), 0);
    chk("t5_oka", 32'(adpcma_ok), 0);
    chk("t5_okb", 32'(adpcmb_ok), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray_ack = 1'b1;
    base = req_log.size();
    repeat (4) @(negedge clk);
    auto_ack = 1'b1;
    chk("t5_noreq", 32'(req_log.size() - base), 0);
    chk("t5_da_hold", 32'(adpcma_data), 0);
    adpcma_roe_n = 1'b0;
    wait_ok("t5", 1, 0, 20);
    chk("t5_fresh_n", 32'(req_log.size() - base), 1);
    chk("t5_fresh_addr", 32'(req_log[base]), 32'h000020);
    chk("t5_fresh_data", 32'(adpcma_data), 32'(byte_of(a_byte(4'h0, 20'h00040))));

    // 6: read enables high, addresses toggling
    adpcma_roe_n = 1'b1;
    base = req_log.size();
    saw_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      adpcma_addr = 20'($urandom); adpcma_bank = 4'($urandom);
      adpcmb_addr = 24'($urandom);
      @(negedge clk);
      if (mem_req) saw_req = 1'b1;
    end
    chk("t6_noreq", 32'(saw_req), 0);
    chk("t6_nlog", 32'(req_log.size() - base), 0);
    chk("t6_da", 32'(adpcma_data), 32'(byte_of(a_byte(4'h0, 20'h00040))));
    chk("t6_db", 32'(adpcmb_data), 0);

    // Random reads against the word-cache model
    ma_v = 1'b1; ma_w = 24'h000020; mb_v = 1'b0; mb_w = '0;
    adpcma_bank = 4'h0; adpcma_addr = 20'h00040;
    adpcma_roe_n = 1'b0; adpcmb_roe_n = 1'b0;
    moved = 0;
    for (int it = 0; it < 30; it++) begin
      int exp_n;
      ack_dly = $urandom_range(0, 3);
      base = req_log.size();
      exp_n = 0;
      if ($urandom_range(0, 1) == 1) begin
        adpcma_bank = 4'($urandom_range(0, 1));
        adpcma_addr = 20'($urandom_range(0, 127));
      end
      if (it == 0 || $urandom_range(0, 1) == 1) adpcmb_addr = 24'($urandom_range(0, 127));
      ab = a_byte(adpcma_bank, adpcma_addr);
      bb = b_byte(adpcmb_addr);
      if (!ma_v || ab[24:1] != ma_w) exp_n++;
      if (!mb_v || bb[24:1] != mb_w) exp_n++;
      ma_v = 1'b1; ma_w = ab[24:1];
      mb_v = 1'b1; mb_w = bb[24:1];
      wait_ok("rnd", 1, 1, 100);
      chk("rnd_da", 32'(adpcma_data), 32'(byte_of(ab)));
      chk("rnd_db", 32'(adpcmb_data), 32'(byte_of(bb)));
      chk("rnd_nreq", 32'(req_log.size() - base), 32'(exp_n));
      @(negedge clk);
    end
    chk("rnd_stable", 32'(moved), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
